spi_slave_hd_regbank: RTL and testbench

- System-clocked half-duplex SPI responder: the slave end of the single-wire half-duplex SPI link, SPI mode 0, MSB first.
- Oversamples spi_clk, spi_cs and spi_io_in in the clk domain.
- Decodes an 8-bit command followed by a 16-bit data phase.
- Serves reads and writes to a local register bank.
- Sits beside the existing half-duplex master.
- The board/top level owns the tristate; this core exposes separate in, out and output-enable signals.

---
 rtl/spi_hd_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_slave_hd_regbank.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave_hd_regbank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_hd_pkg.sv
// rtl/spi_hd_pkg.sv - shared constants and state encoding for the half-duplex SPI link
// Purpose: command framing constants, default widths shared with the master, and
//          the slave FSM state type.
package spi_hd_pkg;

  localparam int CMD_W      = 8;
  localparam int RD_BIT     = 7;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WDATA   = 3'd2,
    TURN    = 3'd3,
    RDATA   = 3'd4,
    WAIT_CS = 3'd5
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detection
// Purpose: brings one asynchronous input into the clk domain.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized level (last stage)
//   rise     : one-clk strobe, rising edge seen between the last two stages
//   fall     : one-clk strobe, falling edge seen between the last two stages
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;

  // Resets to 0 so a CS held low across reset never looks like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = sr[STAGES-2] & ~sr[STAGES-1];
  assign fall = ~sr[STAGES-2] & sr[STAGES-1];

endmodule

// File: rtl/spi_slave_hd_regbank.sv
// rtl/spi_slave_hd_regbank.sv - oversampled half-duplex SPI slave (mode 0) with register bank
// Purpose: decodes an 8-bit command plus DATA_W-bit data phase and serves register
//          reads/writes over a single shared data line.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   spi_clk, spi_cs   : serial clock and active-low chip select from the master
//   spi_io_in         : sampled shared data line
//   spi_io_out/_oe    : value and enable for the shared line (tristate lives outside)
//   usr_addr/usr_rdata: local combinational read port
//   wr_pulse, wr_addr : commit strobe and address of the last SPI write
//   frame_err         : strobe when CS rises in the middle of a frame
//   err_cnt           : saturating abort counter (only with SPI_SLV_ERR_CNT_EN)
// Optional: SPI_SLV_ERR_CNT_EN adds err_cnt and maps reads of the all-ones address to it.
module spi_slave_hd_regbank
  import spi_hd_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_io_in,
  output logic              spi_io_out,
  output logic              spi_io_oe,
  input  logic [ADDR_W-1:0] usr_addr,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_err
`ifdef SPI_SLV_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic io_q, io_rise, io_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi_clk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_io (
    .clk(clk), .rst(rst), .d(spi_io_in), .q(io_q), .rise(io_rise), .fall(io_fall));

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] sh, sh_n, sh_in;
  logic [DATA_W-1:0] shadow, shadow_n;
  logic [DATA_W-1:0] wr_data, wr_data_n;
  logic [ADDR_W-1:0] addr, addr_n, wr_addr_n;
  logic              io_out_n, oe_q, oe_n, wr_pulse_n, frame_err_n;
  logic [DATA_W-1:0] spi_rdata;
  logic [DATA_W-1:0] regs [DEPTH];

  assign sh_in = {sh[DATA_W-2:0], io_q};

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    addr_n      = addr;
    shadow_n    = shadow;
    wr_data_n   = wr_data;
    wr_addr_n   = wr_addr;
    io_out_n    = spi_io_out;
    oe_n        = oe_q;
    wr_pulse_n  = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = CMD;
          cnt_n   = '0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          sh_n  = sh_in;
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(CMD_W - 1)) begin
            cnt_n  = '0;
            addr_n = sh_in[ADDR_W-1:0];
            if (sh_in[RD_BIT]) begin
              state_n  = TURN;
              shadow_n = spi_rdata;
            end else begin
              state_n = WDATA;
            end
          end
        end
      end
      WDATA: begin
        if (sclk_rise) begin
          sh_n  = sh_in;
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            wr_pulse_n = 1'b1;
            wr_addr_n  = addr;
            wr_data_n  = sh_in;
            state_n    = WAIT_CS;
          end
        end
      end
      TURN: begin
        // The fall that ends the command byte arrives here first; only the fall
        // after the dummy rise (cnt marks it) hands the line to the slave.
        if (sclk_rise) begin
          cnt_n = CNT_W'(1);
        end else if (sclk_fall && cnt != '0) begin
          oe_n     = 1'b1;
          io_out_n = shadow[DATA_W-1];
          shadow_n = shadow << 1;
          cnt_n    = '0;
          state_n  = RDATA;
        end
      end
      RDATA: begin
        if (sclk_fall) begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            oe_n     = 1'b0;
            io_out_n = 1'b0;
            state_n  = WAIT_CS;
          end else begin
            io_out_n = shadow[DATA_W-1];
            shadow_n = shadow << 1;
          end
        end
      end
      WAIT_CS: begin
        if (cs_q) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // CS rising mid-frame overrides everything, including a write completing this clk.
    if (cs_rise && (state == CMD || state == WDATA || state == TURN || state == RDATA)) begin
      state_n     = IDLE;
      oe_n        = 1'b0;
      io_out_n    = 1'b0;
      wr_pulse_n  = 1'b0;
      frame_err_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      addr       <= '0;
      shadow     <= '0;
      wr_data    <= '0;
      wr_addr    <= '0;
      spi_io_out <= 1'b0;
      oe_q       <= 1'b0;
      wr_pulse   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      addr       <= addr_n;
      shadow     <= shadow_n;
      wr_data    <= wr_data_n;
      wr_addr    <= wr_addr_n;
      spi_io_out <= io_out_n;
      oe_q       <= oe_n;
      wr_pulse   <= wr_pulse_n;
      frame_err  <= frame_err_n;
    end
  end

  // Commit lands on the edge that ends wr_pulse, so the local port still sees the
  // old contents during the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_pulse) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Belt-and-braces: never drive the line once synced CS is high.
  assign spi_io_oe = oe_q & ~cs_q;

`ifdef SPI_SLV_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (frame_err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign usr_rdata = (&usr_addr) ? DATA_W'(err_cnt) : regs[usr_addr];
  assign spi_rdata = (&sh_in[ADDR_W-1:0]) ? DATA_W'(err_cnt) : regs[sh_in[ADDR_W-1:0]];
`else
  assign usr_rdata = regs[usr_addr];
  assign spi_rdata = regs[sh_in[ADDR_W-1:0]];
`endif

  logic unused_sync;
  assign unused_sync = ^{sclk_q, io_rise, io_fall, sh[DATA_W-1]};

endmodule

// File: tb/tb_spi_slave_hd_regbank.sv
// tb/tb_spi_slave_hd_regbank.sv - scoreboard bench for spi_slave_hd_regbank
module tb_spi_slave_hd_regbank;

  localparam int HP = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_io_in = 1'b0;
  logic        spi_io_out, spi_io_oe, wr_pulse, frame_err;
  logic [3:0]  usr_addr = 4'd0;
  logic [3:0]  wr_addr;
  logic [15:0] usr_rdata;
`ifdef SPI_SLV_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  spi_slave_hd_regbank dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_io_in(spi_io_in),
    .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe), .usr_addr(usr_addr),
    .usr_rdata(usr_rdata), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err)
`ifdef SPI_SLV_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] old_v;
    logic [15:0] new_v;
  } wr_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] mdl [16];
  int          mdl_err = 0;
  wr_t         exp_wr [$];
  int          exp_err [$];
  logic [15:0] exp_rd [$];
  logic [15:0] got_rd [$];
  logic        rd_window = 1'b0;
  int          oe_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [3:0] a);
`ifdef SPI_SLV_ERR_CNT_EN
    if (a == 4'hF) return 16'(mdl_err);
`endif
    return mdl[a];
  endfunction

  task automatic clear_model();
    for (int j = 0; j < 16; j++) mdl[j] = 16'h0;
    mdl_err = 0;
  endtask

  task automatic sweep(input string name);
    for (int j = 0; j < 16; j++) begin
      usr_addr = 4'(j);
      #1;
      chk(name, 32'(usr_rdata), 32'(exp_read(4'(j))));
    end
  endtask

  task automatic bit_cycle(input logic b);
    spi_io_in = b;
    #HP;
    spi_clk = 1'b1;
    #HP;
    spi_clk = 1'b0;
  endtask

  // abort_k: data bits clocked before CS is raised early (-1 none)
  // rst_k  : read bits clocked before reset is pulsed (-1 none)
  // extra  : spare spi_clk pulses after the data phase
  task automatic frame(input logic [7:0] cmd, input logic [15:0] wd,
                       input int abort_k, input int rst_k, input int extra);
    logic [3:0]  a;
    logic        rd;
    logic [15:0] got;
    int          oe_low;
    wr_t         e;
    a = cmd[3:0];
    rd = cmd[7];
    got = 16'h0;
    oe_low = 0;
    usr_addr = a;
    if (abort_k >= 0) begin
      exp_err.push_back(1);
      if (mdl_err < 255) mdl_err++;
    end else if (!rd) begin
      e.a = a;
      e.old_v = exp_read(a);
      mdl[a] = wd;
      e.new_v = exp_read(a);
      exp_wr.push_back(e);
    end else if (rst_k < 0) begin
      exp_rd.push_back(exp_read(a));
    end

    spi_cs = 1'b0;
    #HP;
    for (int i = 7; i >= 0; i--) bit_cycle(cmd[i]);
    if (!rd) begin
      for (int i = 0; i < 16; i++) begin
        if (i == abort_k) break;
        bit_cycle(wd[15-i]);
      end
    end else begin
      spi_io_in = 1'b0;
      #HP;
      chk("oe_before_turn", 32'(spi_io_oe), 32'd0);
      rd_window = 1'b1;
      spi_clk = 1'b1;
      #HP;
      spi_clk = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (i == abort_k) break;
        if (i == rst_k) begin
          rst = 1'b1;
          #1;
          chk("rst_oe_low", 32'(spi_io_oe), 32'd0);
          clear_model();
          sweep("rst_reg_clear");
          rd_window = 1'b0;
          usr_addr = a;
          #HP;
          rst = 1'b0;
        end
        #HP;
        got = {got[14:0], spi_io_out};
        if (spi_io_oe !== 1'b1) oe_low++;
        spi_clk = 1'b1;
        #HP;
        spi_clk = 1'b0;
      end
      if (abort_k < 0 && rst_k < 0) begin
        #HP;
        chk("oe_after_read", 32'(spi_io_oe), 32'd0);
        chk("oe_during_read", 32'(oe_low), 32'd0);
        rd_window = 1'b0;
        got_rd.push_back(got);
      end
    end
    if (abort_k < 0) begin
      for (int i = 0; i < extra; i++) bit_cycle(1'($urandom_range(0, 1)));
    end
    #HP;
    spi_cs = 1'b1;
    #HP;
    rd_window = 1'b0;
    chk("oe_after_cs", 32'(spi_io_oe), 32'd0);
    #(2*HP);
    sweep("reg_sweep");
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or a captured word.
  initial begin
    wr_t         m;
    logic        pend;
    logic [15:0] pend_v;
    pend = 1'b0;
    pend_v = 16'h0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("wr_new_visible", 32'(usr_rdata), 32'(pend_v));
        pend = 1'b0;
      end
      if (spi_io_oe === 1'b1 && !rd_window) oe_viol++;
      if (wr_pulse === 1'b1) begin
        chk("wr_pulse_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          m = exp_wr.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(m.a));
          chk("wr_old_held", 32'(usr_rdata), 32'(m.old_v));
          pend = 1'b1;
          pend_v = m.new_v;
        end
      end
      if (frame_err === 1'b1) begin
        chk("frame_err_expected", 32'(exp_err.size() > 0), 32'd1);
        if (exp_err.size() > 0) void'(exp_err.pop_front());
      end
      if (got_rd.size() > 0) begin
        chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) chk("rd_data", 32'(got_rd.pop_front()), 32'(exp_rd.pop_front()));
        else void'(got_rd.pop_front());
      end
    end
  end

  initial begin
    logic [7:0]  cmd;
    logic [15:0] wd;
    int          ab;
    clear_model();
    #55;
    chk("rst_io_out", 32'(spi_io_out), 32'd0);
    chk("rst_io_oe", 32'(spi_io_oe), 32'd0);
    chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
`ifdef SPI_SLV_ERR_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    sweep("rst_regs");
    rst = 1'b0;
    #(2*HP);

    frame(8'h03, 16'hA5C3, -1, -1, 0);
    frame(8'h83, 16'h0000, -1, -1, 0);
    frame(8'h05, 16'h5A5A, 10, -1, 0);
    frame(8'h85, 16'h0000, -1, -1, 0);
    frame(8'h07, 16'h8001, -1, -1, 0);
    frame(8'h87, 16'h0000, -1, -1, 4);
    frame(8'h83, 16'h0000, -1, 5, 0);
    frame(8'h83, 16'h0000, -1, -1, 0);

    for (int n = 0; n < 40; n++) begin
      cmd = 8'($urandom);
      wd  = 16'($urandom);
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : -1;
      frame(cmd, wd, ab, -1, int'($urandom_range(0, 3)));
    end

`ifdef SPI_SLV_ERR_CNT_EN
    rst = 1'b1;
    #20;
    clear_model();
    rst = 1'b0;
    #(2*HP);
    for (int n = 0; n < 3; n++) frame(8'h01, 16'($urandom), 3, -1, 0);
    frame(8'h8F, 16'h0000, -1, -1, 0);
    chk("err_cnt", 32'(err_cnt), 32'(mdl_err));
`endif

    #(4*HP);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("err_queue_drained", 32'(exp_err.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    chk("oe_outside_read", 32'(oe_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
